// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with per-register scoreboard busy bits.
// Define REGFILE_BYPASS_EN to forward same-edge writes to the read ports.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     rsv_en,
  input  logic [AW-1:0]            rsv_addr,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [AW:0]              busy_cnt
);
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy, busy_nxt;
  logic                rsv_ok, wr_ok, inc, dec;
  assign rsv_ok = rsv_en && rsv_addr != '0;
  assign wr_ok  = wr_en && wr_addr != '0;
  assign inc    = rsv_ok && !busy[rsv_addr];
  assign dec    = wr_ok && busy[wr_addr] && !(rsv_ok && rsv_addr == wr_addr);
  // reserve is applied last so it wins over a same-edge write-back
  always_comb begin
    busy_nxt = busy;
    if (wr_ok) busy_nxt[wr_addr] = 1'b0;
    if (rsv_ok) busy_nxt[rsv_addr] = 1'b1;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (wr_ok) regs[wr_addr] <= wr_data;
      busy     <= busy_nxt;
      busy_cnt <= busy_cnt + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec};
    end
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [AW-1:0]     a;
    logic [DATA_W-1:0] d, dq;
    logic              b, bq;
    assign a = rd_addr[g*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    assign d = (wr_ok && wr_addr == a) ? wr_data : regs[a];
    assign b = busy_nxt[a];
`else
    assign d = regs[a];
    assign b = busy[a];
`endif
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        dq <= '0;
        bq <= 1'b0;
      end else begin
        dq <= d;
        bq <= b;
      end
    assign rd_data[g*DATA_W +: DATA_W] = dq;
    assign rd_busy[g] = bq;
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: table-driven scoreboard bench for regfile_sb (32x32, 2 read ports).
module tb_regfile_sb;
  logic        clk, reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        rsv_en, wr_en;
  logic [4:0]  rsv_addr, wr_addr;
  logic [31:0] wr_data;
  logic [5:0]  busy_cnt;
  int errs = 0, checks = 0;

  regfile_sb dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy_cnt(busy_cnt)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d0;
    logic        b0;
    logic [31:0] d1;
    logic        b1;
    logic [5:0]  cnt;
  } exp_t;

  typedef struct packed {
    logic        re;
    logic [4:0]  ra;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  a0;
    logic [4:0]  a1;
    exp_t        e;
  } vec_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drv(input logic re, input logic [4:0] ra, input logic we,
                     input logic [4:0] wa, input logic [31:0] wd,
                     input logic [4:0] a0, input logic [4:0] a1);
    rsv_en = re; rsv_addr = ra; wr_en = we; wr_addr = wa; wr_data = wd;
    rd_addr = {a1, a0};
  endtask

  task automatic tick_cmp(input string tag);
    exp_t e;
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      errs++; checks++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".d0"}, rd_data[31:0], e.d0);
      chk({tag, ".b0"}, {31'd0, rd_busy[0]}, {31'd0, e.b0});
      chk({tag, ".d1"}, rd_data[63:32], e.d1);
      chk({tag, ".b1"}, {31'd0, rd_busy[1]}, {31'd0, e.b1});
      chk({tag, ".cnt"}, {26'd0, busy_cnt}, {26'd0, e.cnt});
    end
  endtask

  vec_t v[14];

  initial begin
    v[0]  = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        5'd0, 5'd5, '{32'h0, 1'b0, 32'h0, 1'b0, 6'd0}};
    v[1]  = '{1'b1, 5'd3, 1'b0, 5'd0, 32'h0,        5'd0, 5'd5, '{32'h0, 1'b0, 32'h0, 1'b0, 6'd1}};
    v[2]  = '{1'b0, 5'd0, 1'b1, 5'd3, 32'hDEADBEEF, 5'd5, 5'd0, '{32'h0, 1'b0, 32'h0, 1'b0, 6'd0}};
    v[3]  = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        5'd3, 5'd3, '{32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, 6'd0}};
    v[4]  = '{1'b1, 5'd7, 1'b1, 5'd7, 32'h1234,     5'd0, 5'd0, '{32'h0, 1'b0, 32'h0, 1'b0, 6'd1}};
    v[5]  = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        5'd7, 5'd3, '{32'h1234, 1'b1, 32'hDEADBEEF, 1'b0, 6'd1}};
    v[6]  = '{1'b1, 5'd7, 1'b0, 5'd0, 32'h0,        5'd7, 5'd7, '{32'h1234, 1'b1, 32'h1234, 1'b1, 6'd1}};
    v[7]  = '{1'b0, 5'd0, 1'b1, 5'd5, 32'h55,       5'd0, 5'd7, '{32'h0, 1'b0, 32'h1234, 1'b1, 6'd1}};
    v[8]  = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        5'd5, 5'd0, '{32'h55, 1'b0, 32'h0, 1'b0, 6'd1}};
    v[9]  = '{1'b0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd7, 5'd0, '{32'h1234, 1'b1, 32'h0, 1'b0, 6'd1}};
    v[10] = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        5'd0, 5'd0, '{32'h0, 1'b0, 32'h0, 1'b0, 6'd1}};
    v[11] = '{1'b0, 5'd0, 1'b1, 5'd7, 32'h9,        5'd3, 5'd5, '{32'hDEADBEEF, 1'b0, 32'h55, 1'b0, 6'd0}};
    v[12] = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        5'd7, 5'd7, '{32'h9, 1'b0, 32'h9, 1'b0, 6'd0}};
    v[13] = '{1'b1, 5'd0, 1'b0, 5'd0, 32'h0,        5'd0, 5'd7, '{32'h0, 1'b0, 32'h9, 1'b0, 6'd0}};

    reset = 0;
    drv(0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("rst.data", rd_data[31:0] | rd_data[63:32], 32'h0);
    chk("rst.busy", {30'd0, rd_busy}, 32'h0);
    chk("rst.cnt", {26'd0, busy_cnt}, 32'h0);
    reset = 1;
    #4;

    for (int i = 0; i < 14; i++) begin
      drv(v[i].re, v[i].ra, v[i].we, v[i].wa, v[i].wd, v[i].a0, v[i].a1);
      sb.push_back(v[i].e);
      tick_cmp($sformatf("vec%0d", i));
    end

    // same-edge write and read of x9 on port 1
    drv(0, 0, 1, 9, 32'hA5A5A5A5, 0, 9);
`ifdef REGFILE_BYPASS_EN
    sb.push_back('{32'h0, 1'b0, 32'hA5A5A5A5, 1'b0, 6'd0});
`else
    sb.push_back('{32'h0, 1'b0, 32'h0, 1'b0, 6'd0});
`endif
    tick_cmp("byp.wr");
    drv(0, 0, 0, 0, 0, 0, 9);
    sb.push_back('{32'h0, 1'b0, 32'hA5A5A5A5, 1'b0, 6'd0});
    tick_cmp("byp.next");
    // same-edge reserve+write+read of x9
    drv(1, 9, 1, 9, 32'h1, 9, 9);
`ifdef REGFILE_BYPASS_EN
    sb.push_back('{32'h1, 1'b1, 32'h1, 1'b1, 6'd1});
`else
    sb.push_back('{32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5, 1'b0, 6'd1});
`endif
    tick_cmp("byp.rsvwr");
    drv(0, 0, 1, 9, 32'h2, 9, 0);
`ifdef REGFILE_BYPASS_EN
    sb.push_back('{32'h2, 1'b0, 32'h0, 1'b0, 6'd0});
`else
    sb.push_back('{32'h1, 1'b1, 32'h0, 1'b0, 6'd0});
`endif
    tick_cmp("byp.clr");

    // reserve x1..x31 back to back, then reset mid-cycle
    for (int i = 1; i < 32; i++) begin
      drv(1, 5'(i), 0, 0, 0, 0, 0);
      @(posedge clk); #1;
    end
    chk("fill.cnt", {26'd0, busy_cnt}, 32'd31);
    drv(1, 5'd1, 0, 0, 0, 5'd1, 5'd3);
    @(posedge clk); #1;
    chk("fill.busy", {30'd0, rd_busy}, 32'h3);
    #2 reset = 0;
    #1;
    chk("arst.cnt", {26'd0, busy_cnt}, 32'd0);
    chk("arst.busy", {30'd0, rd_busy}, 32'h0);
    chk("arst.data", rd_data[31:0] | rd_data[63:32], 32'h0);
    reset = 1;
    drv(1, 4, 0, 0, 0, 3, 0);
    sb.push_back('{32'h0, 1'b0, 32'h0, 1'b0, 6'd1});
    tick_cmp("post.rsv");
    drv(0, 0, 1, 0, 32'hFFFFFFFF, 4, 0);
    sb.push_back('{32'h0, 1'b1, 32'h0, 1'b0, 6'd1});
    tick_cmp("post.wr0");
    drv(0, 0, 0, 0, 0, 0, 0);
    sb.push_back('{32'h0, 1'b0, 32'h0, 1'b0, 6'd1});
    tick_cmp("post.rd0");

    chk("sb.empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
